// File: rtl/branch_resolve_ctrl.sv
// Branch predictor (2-bit saturating BHT) and mispredict recovery controller.
// Resolves EX-stage branches/jumps and sequences the redirect/flush/stall handshake.
module branch_resolve_ctrl #(
  parameter int BHT_BITS = 6,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic [2:0]       ex_branctrl,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             ex_cond_taken,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             ex_stall,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispred
);

  localparam logic [2:0]       BNONE   = 3'b000;
  localparam int               ENTRIES = 1 << BHT_BITS;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {RUN = 1'b0, REDIR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branches_q, branches_d;
  logic [CNT_W-1:0] mispred_q, mispred_d;
  logic [1:0]       bht_q [ENTRIES];
  logic [1:0]       bht_d [ENTRIES];

  logic [BHT_BITS-1:0] if_idx;
  logic [BHT_BITS-1:0] ex_idx;
  logic                is_jump;
  logic                is_cond;
  logic                resolve;
  logic                taken;
  logic                mispred;
  logic                unused_pc_bits;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'd3) ? cnt : cnt + 2'd1;
    else    return (cnt == 2'd0) ? cnt : cnt - 2'd1;
  endfunction

  assign if_idx         = if_pc[BHT_BITS+1:2];
  assign ex_idx         = ex_pc[BHT_BITS+1:2];
  assign unused_pc_bits = ^{if_pc[31:BHT_BITS+2], if_pc[1:0]};

  // Read is from the registered table only, so a same-cycle update is not bypassed.
  assign if_pred_taken = bht_q[if_idx][1];

  assign is_jump = ex_is_jal | ex_is_jalr;
  assign is_cond = (ex_branctrl != BNONE) && !is_jump;
  assign resolve = ex_valid && (state_q == RUN) && (is_cond || is_jump);
  assign taken   = is_jump | ex_cond_taken;
  assign mispred = is_jump | (ex_cond_taken != ex_pred_taken);

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    branches_d    = branches_q;
    mispred_d     = mispred_q;
    bht_d         = bht_q;
    if (state_q == RUN) begin
      if (resolve) begin
        if (is_cond) begin
          branches_d     = branches_q + CNT_ONE;
          bht_d[ex_idx]  = sat_step(bht_q[ex_idx], ex_cond_taken);
        end
        if (mispred) begin
          mispred_d     = mispred_q + CNT_ONE;
          state_d       = REDIR;
          redirect_pc_d = taken ? ex_target : ex_pc + 32'd4;
        end
      end
    end else if (redirect_ready) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      redirect_pc_q <= '0;
      branches_q    <= '0;
      mispred_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'd1;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      branches_q    <= branches_d;
      mispred_q     <= mispred_d;
      bht_q         <= bht_d;
    end
  end

  // Wrong-path instructions are held off for the whole redirect window.
  assign redirect_valid = (state_q == REDIR);
  assign flush_if_id    = (state_q == REDIR);
  assign flush_id_ex    = (state_q == REDIR);
  assign ex_stall       = (state_q == REDIR);
  assign redirect_pc    = redirect_pc_q;
  assign stat_branches  = branches_q;
  assign stat_mispred   = mispred_q;

endmodule
